iterative_muldiv: RTL and testbench
===================================

Name: iterative_muldiv

Overview:
- Sequential RV32M/RV64M execution unit for multiply, divide and remainder, parameterised in XLEN.
- The multicycle and pipelined cores stall on its valid/ready handshake.
- The ALU control stage routes funct7[0]=1 OP instructions here instead of to the combinational ALU.
- Algorithm: radix-2 shift-add multiply and restoring divide on operand magnitudes, with a sign-fixup cycle. Division-by-zero and signed overflow finish on a fast path.

Parameters:
- XLEN, 32, operand and result width; legal values are 32 and 64.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- kill  in  1  abort the operation in flight; highest priority after reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request; high only in IDLE
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  XLEN  rs1 value (multiplicand or dividend)
- operand_b  in  XLEN  rs2 value (multiplier or divisor)
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  operation result

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=1, out_valid=0, result=0.
  - All datapath registers are cleared.
  - Reset takes effect mid-operation with no output produced.
- Accept:
  - A request is accepted on a rising edge where in_valid && in_ready.
  - funct3, the operand signs and the magnitudes are latched at that edge.
  - Inputs are ignored outside IDLE.
- Signedness:
  - Operand a is signed for MULH, MULHSU, DIV, REM.
  - Operand b is signed for MULH, DIV, REM.
  - MUL result is the low XLEN bits and is sign-agnostic.
  - A signed operand's magnitude is its two's-complement negation when its MSB is 1. The magnitude of the most negative value is 2^(XLEN-1) as unsigned.
- FSM states: IDLE, BUSY, FIXUP, DONE.
- IDLE:
  - On accept of a divide op with operand_b==0, or DIV/REM with a=MIN_INT and b=-1, go to DONE with the special result.
  - Any other accepted op goes to BUSY with the iteration counter = XLEN-1.
- BUSY (multiply): add the multiplicand to the 2*XLEN accumulator when the multiplier LSB is 1, then shift.
- BUSY (divide): shift the remainder left by one dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- BUSY exit: exactly XLEN cycles, then go to FIXUP when the counter reaches 0.
- FIXUP (multiply):
  - Negate the 2*XLEN product if the operand signs differ (signed operands only).
  - MUL selects [XLEN-1:0]; MULH, MULHSU, MULHU select [2XLEN-1:XLEN].
- FIXUP (divide):
  - Negate the quotient if sign(a)!=sign(b) (DIV).
  - Negate the remainder if sign(a)=1 (REM).
- FIXUP exit: register result and go to DONE.
- DONE: hold result stable while out_valid=1 && out_ready=0. Return to IDLE on the edge where out_ready=1.
- No back-to-back overlap: a new request is accepted only in IDLE, so at the earliest one cycle after the result handshake.
- Latency: out_valid rises XLEN+2 edges after the accept edge in the normal case, and 1 edge after it on the fast path.
- Special results:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = operand_a.
  - Overflow (DIV with MIN_INT/-1): quotient = MIN_INT, REM = 0.
  - Unsigned ops never take the overflow path.
- kill:
  - kill=1 at an edge forces IDLE from any state and drops out_valid; no result is produced.
  - kill and accept in the same cycle: kill wins and the request is not accepted.
- Zero operands:
  - Multiply by 0 still takes the full latency and returns 0.
  - Divide with dividend 0 gives quotient 0 and remainder 0.

Test Plan:
- Reset mid-BUSY (MUL 7*3 accepted, reset_n low 5 cycles later) -> out_valid=0 and in_ready=1 immediately on reset assertion; a subsequent MUL 7*3 returns 21.
- MUL 7 * 0xFFFFFFFD (XLEN=32), out_ready=1 -> result 0xFFFFFFEB, out_valid exactly 34 edges after the accept edge.
- MULH/MULHSU/MULHU on 0x80000000*0x80000000 -> 0x40000000 / 0xC0000000 / 0x40000000. On 0xFFFFFFFF*0xFFFFFFFF -> MULH 0x00000000, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE.
- DIV/REM/DIVU/REMU with a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD, 0xFFFFFFFF, 0x7FFFFFFC, 0x00000001.
- Fast path:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All of these show out_valid 1 edge after accept.
- Backpressure and kill:
  - out_ready held low 10 cycles -> result stable and in_ready=0 throughout; result is released on out_ready=1.
  - kill asserted mid-BUSY -> no out_valid, in_ready=1 next cycle.
  - kill concurrent with in_valid in IDLE -> request dropped.

Source files
------------

// File: rtl/iterative_muldiv_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
interface iterative_muldiv_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  // Requester side: issues operations and consumes results
  modport master (
    output in_valid,
    input  in_ready,
    output funct3,
    output operand_a,
    output operand_b,
    input  out_valid,
    output out_ready,
    input  result
  );

  // Execution unit side
  modport slave (
    input  in_valid,
    output in_ready,
    input  funct3,
    input  operand_a,
    input  operand_b,
    output out_valid,
    input  out_ready,
    output result
  );

endinterface

// File: rtl/iterative_muldiv.sv
// Sequential RV32M/RV64M unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, followed by a sign-fixup cycle. Divide-by-zero and
// signed overflow bypass the iteration and complete on the accept edge.
module iterative_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              kill,
  iterative_muldiv_if.slave bus
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [2:0]      f3_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [XLEN-1:0] mag_q;   // multiplicand (multiply) or divisor (divide)
  logic [W2-1:0]   acc_q;   // {partial product, multiplier} or {remainder, quotient}
  logic [CW-1:0]   cnt_q;

  // Request decode: signedness, magnitudes and fast-path detection
  logic            is_div_c;
  logic            a_signed_c;
  logic            b_signed_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic [XLEN-1:0] a_mag_c;
  logic [XLEN-1:0] b_mag_c;
  logic            div_zero_c;
  logic            ovf_c;
  logic [XLEN-1:0] fast_res_c;

  always_comb begin
    is_div_c   = bus.funct3[2];
    a_signed_c = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                 (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    b_signed_c = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) ||
                 (bus.funct3 == F_REM);
    a_neg_c    = a_signed_c && bus.operand_a[XLEN-1];
    b_neg_c    = b_signed_c && bus.operand_b[XLEN-1];
    a_mag_c    = a_neg_c ? (~bus.operand_a) + XLEN'(1) : bus.operand_a;
    b_mag_c    = b_neg_c ? (~bus.operand_b) + XLEN'(1) : bus.operand_b;
    div_zero_c = is_div_c && (bus.operand_b == '0);
    ovf_c      = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                 (bus.operand_a == MIN_INT) && (bus.operand_b == '1);
    fast_res_c = '0;
    if (div_zero_c) begin
      fast_res_c = bus.funct3[1] ? bus.operand_a : '1;
    end else if (ovf_c) begin
      fast_res_c = bus.funct3[1] ? '0 : MIN_INT;
    end
  end

  // One iteration step for both algorithms
  logic [XLEN:0]   hi_sum_c;
  logic [W2-1:0]   mul_next_c;
  logic [XLEN:0]   shifted_c;
  logic [XLEN:0]   trial_c;
  logic            q_bit_c;
  logic [XLEN-1:0] new_rem_c;
  logic [W2-1:0]   div_next_c;

  always_comb begin
    hi_sum_c   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next_c = {hi_sum_c, acc_q[XLEN-1:1]};
    shifted_c  = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    trial_c    = shifted_c - {1'b0, mag_q};
    q_bit_c    = ~trial_c[XLEN];
    new_rem_c  = q_bit_c ? trial_c[XLEN-1:0] : shifted_c[XLEN-1:0];
    div_next_c = {new_rem_c, acc_q[XLEN-2:0], q_bit_c};
  end

  // Sign fixup and result selection
  logic [W2-1:0]   prod_c;
  logic [XLEN-1:0] quot_c;
  logic [XLEN-1:0] rem_c;
  logic [XLEN-1:0] fix_res_c;

  always_comb begin
    prod_c    = (a_neg_q ^ b_neg_q) ? (~acc_q) + W2'(1) : acc_q;
    quot_c    = acc_q[XLEN-1:0];
    rem_c     = acc_q[W2-1:XLEN];
    fix_res_c = '0;
    case (f3_q)
      F_MUL:                     fix_res_c = prod_c[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_res_c = prod_c[W2-1:XLEN];
      F_DIV:  fix_res_c = (a_neg_q ^ b_neg_q) ? (~quot_c) + XLEN'(1) : quot_c;
      F_DIVU: fix_res_c = quot_c;
      F_REM:  fix_res_c = a_neg_q ? (~rem_c) + XLEN'(1) : rem_c;
      F_REMU: fix_res_c = rem_c;
      default: fix_res_c = '0;
    endcase
  end

  // Control FSM and datapath registers; kill aborts from any state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      f3_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else if (kill) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            f3_q       <= bus.funct3;
            a_neg_q    <= a_neg_c;
            b_neg_q    <= b_neg_c;
            in_ready_q <= 1'b0;
            if (div_zero_c || ovf_c) begin
              result_q    <= fast_res_c;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              mag_q   <= is_div_c ? b_mag_c : a_mag_c;
              acc_q   <= {{XLEN{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
              cnt_q   <= CW'(XLEN - 1);
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_q <= f3_q[2] ? div_next_c : mul_next_c;
          if (cnt_q == '0) begin
            state_q <= S_FIXUP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIXUP: begin
          result_q    <= fix_res_c;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed-vector bench for iterative_muldiv at XLEN=32.
module tb_iterative_muldiv;

  localparam int unsigned XLEN = 32;

  logic clock;
  logic reset_n;
  logic kill;
  int   errors;
  int   checks;

  iterative_muldiv_if #(.XLEN(XLEN)) bus ();

  iterative_muldiv #(.XLEN(XLEN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .kill    (kill),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one request, wait for its result; lat counts edges with the accept edge as 1
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit tmo);
    @(negedge clock);
    bus.funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid  = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    tmo = !bus.out_valid;
    res = bus.result;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int lat;
    bit tmo;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    @(negedge clock);
    reset_n = 1'b1;
    // Reset in the middle of a multiply
    @(negedge clock);
    bus.funct3 = 3'b000; bus.operand_a = 32'd7; bus.operand_b = 32'd3; bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midbusy_reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midbusy_reset_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    do_op(3'b000, 32'd7, 32'd3, r, lat, tmo);
    checks++;
    if (tmo || r !== 32'd21) begin errors++; $display("FAIL post_reset_mul: got %h (timeout=%0d) expected 00000015", r, tmo); end
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    bit tmo;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, tmo);
    checks++;
    if (tmo || r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_7_m3: got %h expected ffffffeb", r); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL mul_latency: got %0d edges expected 34", lat); end
    do_op(3'b000, 32'd0, 32'd5, r, lat, tmo);
    checks++;
    if (tmo || r !== 32'h0 || lat !== 34) begin errors++; $display("FAIL mul_zero: got %h lat %0d expected 00000000 lat 34", r, lat); end
  endtask

  task automatic test_mulh();
    logic [31:0] r;
    int lat;
    bit tmo;
    logic [2:0]  f3v [6]  = '{3'b001, 3'b010, 3'b011, 3'b001, 3'b010, 3'b011};
    logic [31:0] av  [6]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exv [6]  = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000,
                              32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 6; i++) begin
      do_op(f3v[i], av[i], av[i], r, lat, tmo);
      checks++;
      if (tmo || r !== exv[i]) begin
        errors++;
        $display("FAIL mulh_vec%0d: funct3 %b got %h expected %h", i, f3v[i], r, exv[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    bit tmo;
    logic [2:0]  f3v [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] exv [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      do_op(f3v[i], 32'hFFFF_FFF9, 32'd2, r, lat, tmo);
      checks++;
      if (tmo || r !== exv[i]) begin
        errors++;
        $display("FAIL div_vec%0d: funct3 %b got %h expected %h", i, f3v[i], r, exv[i]);
      end
    end
    do_op(3'b101, 32'd100, 32'd7, r, lat, tmo);
    checks++;
    if (tmo || r !== 32'd14 || lat !== 34) begin errors++; $display("FAIL divu_100_7: got %h lat %0d expected 0000000e lat 34", r, lat); end
    do_op(3'b110, 32'd0, 32'd5, r, lat, tmo);
    checks++;
    if (tmo || r !== 32'h0) begin errors++; $display("FAIL rem_zero_dividend: got %h expected 00000000", r); end
  endtask

  task automatic test_fast_path();
    logic [31:0] r;
    int lat;
    bit tmo;
    logic [2:0]  f3v [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b101};
    logic [31:0] av  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exv [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'h0};
    int          exl [5] = '{1, 1, 1, 1, 34};
    for (int i = 0; i < 5; i++) begin
      do_op(f3v[i], av[i], bv[i], r, lat, tmo);
      checks++;
      if (tmo || r !== exv[i] || lat !== exl[i]) begin
        errors++;
        $display("FAIL fast_vec%0d: got %h lat %0d expected %h lat %0d", i, r, lat, exv[i], exl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit bad;
    bus.out_ready = 1'b0;
    @(negedge clock);
    bus.funct3 = 3'b000; bus.operand_a = 32'd5; bus.operand_b = 32'd6; bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clock); #1; n++; end
    bad = !bus.out_valid;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd30 || bus.in_ready !== 1'b0) bad = 1'b1;
      @(posedge clock);
      #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL backpressure_hold: got valid %b result %h ready %b expected 1 0000001e 0", bus.out_valid, bus.result, bus.in_ready); end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release: got valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat;
    bit tmo;
    bit seen;
    @(negedge clock);
    bus.funct3 = 3'b101; bus.operand_a = 32'd100; bus.operand_b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    kill = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL kill_busy: got ready %b valid %b expected 1 0", bus.in_ready, bus.out_valid); end
    @(negedge clock);
    kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clock); #1; if (bus.out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL kill_no_result: got out_valid 1 expected 0"); end
    // Kill and request in the same cycle: request must be dropped
    @(negedge clock);
    kill = 1'b1;
    bus.funct3 = 3'b000; bus.operand_a = 32'd2; bus.operand_b = 32'd3; bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL kill_accept_ready: got %b expected 1", bus.in_ready); end
    @(negedge clock);
    kill = 1'b0;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clock); #1; if (bus.out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL kill_accept_dropped: got out_valid 1 expected 0"); end
    do_op(3'b101, 32'd100, 32'd7, r, lat, tmo);
    checks++;
    if (tmo || r !== 32'd14) begin errors++; $display("FAIL post_kill_divu: got %h expected 0000000e", r); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    kill = 1'b0;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.funct3 = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.out_ready = 1'b1;
    #2;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_backpressure();
    test_kill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
